// File: rtl/ibex_register_file_mp_if.sv
// Register-file access bundle: read ports, write ports, scoreboard lock and clear control.
interface ibex_register_file_mp_if #(
    parameter int DataWidth = 32,
    parameter int NumRead   = 2,
    parameter int NumWrite  = 2
);
    logic [NumRead-1:0][4:0]            raddr;
    logic [NumRead-1:0][DataWidth-1:0]  rdata;
    logic [NumRead-1:0]                 rbusy;
    logic [NumWrite-1:0][4:0]           waddr;
    logic [NumWrite-1:0][DataWidth-1:0] wdata;
    logic [NumWrite-1:0]                we;
    logic                               lock;
    logic [4:0]                         lock_addr;
    logic                               clear_req;
    logic                               clear_busy;

    modport master (output raddr, waddr, wdata, we, lock, lock_addr, clear_req,
                    input  rdata, rbusy, clear_busy);
    modport slave  (input  raddr, waddr, wdata, we, lock, lock_addr, clear_req,
                    output rdata, rbusy, clear_busy);
endinterface

// File: rtl/ibex_register_file_mp.sv
// Multi-port flip-flop register file with pending scoreboard, write bypass and a sequenced clear engine.
module ibex_rf_read_port #(
    parameter bit RV32E       = 1'b0,
    parameter int DataWidth   = 32,
    parameter int AddrWidth   = 5,
    parameter int NumWords    = 32,
    parameter bit WriteBypass = 1'b1
) (
    input  logic [4:0]                         raddr,
    input  logic [NumWords-1:0][DataWidth-1:0] regs,
    input  logic [NumWords-1:0]                pending,
    input  logic [NumWords-1:0]                wr_en,
    input  logic [NumWords-1:0][DataWidth-1:0] wr_data,
    output logic [DataWidth-1:0]               rdata,
    output logic                               rbusy
);
    logic                 in_range;
    logic                 hit;
    logic [AddrWidth-1:0] idx;

    assign in_range = !RV32E || !raddr[4];
    assign idx      = raddr[AddrWidth-1:0];
    // wr_en is already suppressed during clear, so bypass is off there too
    assign hit      = WriteBypass && in_range && wr_en[idx];
    assign rdata    = !in_range ? '0 : (hit ? wr_data[idx] : regs[idx]);
    assign rbusy    = in_range && pending[idx] && !hit;
endmodule

module ibex_register_file_mp #(
    parameter bit RV32E       = 1'b0,
    parameter int DataWidth   = 32,
    parameter int NumRead     = 2,
    parameter int NumWrite    = 2,
    parameter bit WriteBypass = 1'b1
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    ibex_register_file_mp_if.slave  rf
);
    localparam int AddrWidth = RV32E ? 4 : 5;
    localparam int NumWords  = 2 ** AddrWidth;

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e                             state_q, state_d;
    logic [AddrWidth-1:0]               cnt_q, cnt_d;
    logic                               busy;
    logic [NumWords-1:0][DataWidth-1:0] regs;
    logic [NumWords-1:0]                pending;
    logic [NumWords-1:0]                wr_en;
    logic [NumWords-1:0][DataWidth-1:0] wr_data;
    logic [NumWords-1:0]                lock_en;
    logic [NumRead-1:0][DataWidth-1:0]  rdata;
    logic [NumRead-1:0]                 rbusy;

    assign busy          = (state_q == CLEAR);
    assign rf.clear_busy = busy;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (rf.clear_req) begin
                state_d = CLEAR;
                cnt_d   = AddrWidth'(1);
            end
            CLEAR: if (cnt_q == AddrWidth'(NumWords - 1)) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Walk ports high-to-low so the lowest port index wins a collision.
    // Out-of-range RV32E addresses never match a word index.
    always_comb begin
        wr_en   = '0;
        wr_data = '0;
        lock_en = '0;
        for (int w = 1; w < NumWords; w++) begin
            for (int p = NumWrite - 1; p >= 0; p--) begin
                if (rf.we[p] && rf.waddr[p] == 5'(w)) begin
                    wr_en[w]   = !busy;
                    wr_data[w] = rf.wdata[p];
                end
            end
            lock_en[w] = !busy && rf.lock && rf.lock_addr == 5'(w);
        end
    end

    // Word 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs    <= '0;
            pending <= '0;
        end else begin
            for (int w = 1; w < NumWords; w++) begin
                if (busy && cnt_q == AddrWidth'(w)) begin
                    regs[w]    <= '0;
                    pending[w] <= 1'b0;
                end else begin
                    if (wr_en[w]) regs[w] <= wr_data[w];
                    // A lock alongside a write keeps the word pending for the newer producer
                    if (lock_en[w])     pending[w] <= 1'b1;
                    else if (wr_en[w])  pending[w] <= 1'b0;
                end
            end
        end
    end

    for (genvar k = 0; k < NumRead; k++) begin : g_rd
        ibex_rf_read_port #(
            .RV32E       (RV32E),
            .DataWidth   (DataWidth),
            .AddrWidth   (AddrWidth),
            .NumWords    (NumWords),
            .WriteBypass (WriteBypass)
        ) u_rd (
            .raddr   (rf.raddr[k]),
            .regs    (regs),
            .pending (pending),
            .wr_en   (wr_en),
            .wr_data (wr_data),
            .rdata   (rdata[k]),
            .rbusy   (rbusy[k])
        );
    end

    assign rf.rdata = rdata;
    assign rf.rbusy = rbusy;
endmodule

// File: tb/tb_ibex_register_file_mp.sv
// Drives three register-file configurations with shared stimulus and checks each against an array model.
module tb_ibex_register_file_mp;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ibex_register_file_mp_if #(.DataWidth(32), .NumRead(2), .NumWrite(2)) im ();
    ibex_register_file_mp_if #(.DataWidth(32), .NumRead(2), .NumWrite(2)) inb ();
    ibex_register_file_mp_if #(.DataWidth(32), .NumRead(2), .NumWrite(2)) ie ();

    assign inb.raddr = im.raddr;      assign ie.raddr = im.raddr;
    assign inb.waddr = im.waddr;      assign ie.waddr = im.waddr;
    assign inb.wdata = im.wdata;      assign ie.wdata = im.wdata;
    assign inb.we = im.we;            assign ie.we = im.we;
    assign inb.lock = im.lock;        assign ie.lock = im.lock;
    assign inb.lock_addr = im.lock_addr; assign ie.lock_addr = im.lock_addr;
    assign inb.clear_req = im.clear_req; assign ie.clear_req = im.clear_req;

    ibex_register_file_mp #(.RV32E(1'b0), .DataWidth(32), .NumRead(2), .NumWrite(2), .WriteBypass(1'b1))
        u_main (.clk_i(clk), .rst_ni(rst_n), .rf(im));
    ibex_register_file_mp #(.RV32E(1'b0), .DataWidth(32), .NumRead(2), .NumWrite(2), .WriteBypass(1'b0))
        u_nb (.clk_i(clk), .rst_ni(rst_n), .rf(inb));
    ibex_register_file_mp #(.RV32E(1'b1), .DataWidth(32), .NumRead(2), .NumWrite(2), .WriteBypass(1'b1))
        u_e (.clk_i(clk), .rst_ni(rst_n), .rf(ie));

    // Model: index 0 = default, 1 = no bypass, 2 = RV32E
    logic [31:0] mem  [3][32];
    bit          pend [3][32];
    bit          mbusy[3];
    int          mcnt [3];
    int n_chk  = 0;
    int n_fail = 0;

    function automatic int nwords(int d);
        return (d == 2) ? 16 : 32;
    endfunction

    function automatic bit valid(int d, int a);
        return a != 0 && a < nwords(d);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            mbusy[d] = 0; mcnt[d] = 0;
            for (int a = 0; a < 32; a++) begin mem[d][a] = 0; pend[d][a] = 0; end
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            if (mbusy[d]) begin
                mem[d][mcnt[d]] = 0; pend[d][mcnt[d]] = 0;
                mcnt[d]++;
                if (mcnt[d] == nwords(d)) mbusy[d] = 0;
            end else begin
                for (int p = 1; p >= 0; p--)
                    if (im.we[p] && valid(d, im.waddr[p])) begin
                        mem[d][im.waddr[p]] = im.wdata[p];
                        pend[d][im.waddr[p]] = 0;
                    end
                if (im.lock && valid(d, im.lock_addr)) pend[d][im.lock_addr] = 1;
                if (im.clear_req) begin mbusy[d] = 1; mcnt[d] = 1; end
            end
        end
    endtask

    task automatic exp_read(input int d, input int k, output logic [31:0] data, output logic rb);
        int a;
        a = int'(im.raddr[k]);
        data = 0; rb = 0;
        if (!valid(d, a)) return;
        data = mem[d][a]; rb = pend[d][a];
        if (d != 1 && !mbusy[d])
            for (int p = 1; p >= 0; p--)
                if (im.we[p] && int'(im.waddr[p]) == a) begin data = im.wdata[p]; rb = 0; end
    endtask

    function automatic logic [31:0] act_rdata(int d, int k);
        case (d)
            0: return im.rdata[k];
            1: return inb.rdata[k];
            default: return ie.rdata[k];
        endcase
    endfunction

    function automatic logic act_rbusy(int d, int k);
        case (d)
            0: return im.rbusy[k];
            1: return inb.rbusy[k];
            default: return ie.rbusy[k];
        endcase
    endfunction

    function automatic logic act_cbusy(int d);
        case (d)
            0: return im.clear_busy;
            1: return inb.clear_busy;
            default: return ie.clear_busy;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] ed;
        logic        eb;
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 2; k++) begin
                exp_read(d, k, ed, eb);
                chk($sformatf("cfg%0d_rdata%0d_x%0d", d, k, im.raddr[k]), act_rdata(d, k), ed);
                chk($sformatf("cfg%0d_rbusy%0d_x%0d", d, k, im.raddr[k]), {31'b0, act_rbusy(d, k)}, {31'b0, eb});
            end
            chk($sformatf("cfg%0d_clear_busy", d), {31'b0, act_cbusy(d)}, {31'b0, mbusy[d]});
        end
    endtask

    task automatic tick();
        #1 check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        im.we = '0; im.lock = 0; im.lock_addr = '0; im.clear_req = 0;
        im.waddr = '0; im.wdata = '0;
    endtask

    task automatic write(input int p, input int a, input logic [31:0] v);
        im.we[p] = 1; im.waddr[p] = 5'(a); im.wdata[p] = v;
    endtask

    task automatic fill_index();
        for (int i = 1; i < 32; i += 2) begin
            idle();
            write(0, i, 32'(i));
            if (i < 31) write(1, i + 1, 32'(i + 1));
            tick();
        end
        idle();
    endtask

    initial begin
        int n;
        rst_n = 1;
        idle();
        im.raddr = '0;
        model_reset();
        #1 rst_n = 0;

        for (int a = 0; a < 32; a++) begin
            im.raddr[0] = 5'(a); im.raddr[1] = 5'(31 - a);
            #1 check_outputs();
        end
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        write(0, 4, 32'h44); tick(); idle();
        // Colliding writes: port 0 wins
        write(0, 5, 32'hDEADBEEF); write(1, 5, 32'h12345678); im.raddr[0] = 5;
        #1 chk("x5_bypass_main", im.rdata[0], 32'hDEADBEEF);
        chk("x5_nobypass_old", inb.rdata[0], 32'h0);
        tick(); idle();
        #1 chk("x5_stored_nb", inb.rdata[0], 32'hDEADBEEF);
        tick();

        write(0, 0, 32'hFFFFFFFF); im.lock = 1; im.lock_addr = 0; im.raddr[0] = 0; tick(); idle(); tick();
        write(1, 20, 32'hA5A5A5A5); im.raddr[0] = 20; im.raddr[1] = 4; tick(); idle();
        #1 chk("rv32e_x20_zero", ie.rdata[0], 32'h0);
        chk("rv32e_x4_kept", ie.rdata[1], 32'h44);
        tick();

        im.lock = 1; im.lock_addr = 7; tick(); idle();
        im.raddr[0] = 7;
        #1 chk("x7_busy", {31'b0, im.rbusy[0]}, 32'h1);
        tick();
        write(1, 7, 32'h77);
        #1 chk("x7_bypass", im.rdata[0], 32'h77);
        chk("x7_bypass_notbusy", {31'b0, im.rbusy[0]}, 32'h0);
        tick(); idle(); tick();

        write(0, 9, 32'h99); im.lock = 1; im.lock_addr = 9; tick(); idle();
        im.raddr[0] = 9;
        #1 chk("x9_lock_wins", {31'b0, im.rbusy[0]}, 32'h1);
        tick();

        fill_index();
        im.clear_req = 1; im.lock = 1; im.lock_addr = 3; tick(); idle();
        n = 0;
        while (im.clear_busy && n < 40) begin
            im.raddr[0] = 5'($urandom_range(0, 31)); im.raddr[1] = 5'($urandom_range(0, 31));
            if (n == 5) write(0, 31, 32'h55);
            if (n == 3) im.clear_req = 1;
            tick(); idle();
            n++;
        end
        chk("clear_busy_cycles", 32'(n), 32'd31);
        for (int a = 0; a < 32; a++) begin
            im.raddr[0] = 5'(a); im.raddr[1] = 5'(31 - a);
            #1 chk($sformatf("cleared_x%0d", a), im.rdata[0], 32'h0);
            tick();
        end

        fill_index();
        im.clear_req = 1; tick(); idle();
        for (int i = 0; i < 9; i++) begin
            im.raddr[0] = 5'($urandom_range(0, 31)); im.raddr[1] = 5'($urandom_range(0, 31));
            tick();
        end
        rst_n = 0;
        model_reset();
        #1 chk("rst_mid_clear_busy", {31'b0, im.clear_busy}, 32'h0);
        for (int a = 0; a < 32; a++) begin
            im.raddr[0] = 5'(a); im.raddr[1] = 5'(31 - a);
            #1 check_outputs();
        end
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        write(0, 2, 32'h2); tick(); idle();
        im.raddr[0] = 2;
        #1 chk("x2_after_rst", im.rdata[0], 32'h2);
        tick();

        for (int i = 0; i < 400; i++) begin
            im.raddr[0] = 5'($urandom_range(0, 31)); im.raddr[1] = 5'($urandom_range(0, 31));
            im.we = 2'($urandom_range(0, 3));
            im.waddr[0] = 5'($urandom_range(0, 31));
            im.waddr[1] = ($urandom_range(0, 3) == 0) ? im.waddr[0] : 5'($urandom_range(0, 31));
            im.wdata[0] = $urandom; im.wdata[1] = $urandom;
            im.lock = ($urandom_range(0, 3) == 0);
            im.lock_addr = ($urandom_range(0, 2) == 0) ? im.waddr[0] : 5'($urandom_range(0, 31));
            im.clear_req = ($urandom_range(0, 59) == 0);
            tick();
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
